// File: rtl/relu_maxpool_22_layer2.sv
// rtl/relu_maxpool_22_layer2.sv - ReLU + 2x2 stride-2 max pool + rescale/saturate for conv layer 2
// Raster-order input, one channel at a time; pooled output registered one cycle after the window completes.
module relu_maxpool_22_layer2 #(
  parameter int I_BW    = 20,
  parameter int O_BW    = 16,
  parameter int C_SIZE  = 8,
  parameter int CO      = 4,
  parameter int Q_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   global_rst_n,
  input  logic                   rst,
  input  logic signed [I_BW-1:0] i_conv_result,
  input  logic                   i_conv_valid,
  output logic [O_BW-1:0]        o_pool_result,
  output logic                   o_pool_valid,
  output logic                   o_pool_end,
  output logic                   o_pool_all_end
);

  localparam int CW  = $clog2(C_SIZE);
  localparam int CHW = $clog2(CO) + 1;
  localparam int LBN = C_SIZE / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;
  localparam logic [CW-1:0]          LAST  = CW'(C_SIZE - 1);
  localparam logic [CHW-1:0]         CH_DONE = CHW'(CO);
  localparam logic signed [I_BW-1:0] O_MAX = I_BW'((1 << (O_BW - 1)) - 1);

  logic [CW-1:0]          col;
  logic [CW-1:0]          row;
  logic [CHW-1:0]         ch;
  logic signed [I_BW-1:0] h_hold;
  logic signed [I_BW-1:0] lb [LBN];

  logic                   accept;
  logic                   last;
  logic [LBW-1:0]         lb_idx;
  logic signed [I_BW-1:0] hmax;
  logic signed [I_BW-1:0] vmax;
  logic signed [I_BW-1:0] relu;
  logic signed [I_BW-1:0] shifted;
  logic [O_BW-1:0]        sat;

  always_comb begin
    accept  = i_conv_valid && !rst && (ch != CH_DONE);
    last    = (row == LAST) && (col == LAST);
    lb_idx  = LBW'(col >> 1);
    hmax    = (i_conv_result > h_hold) ? i_conv_result : h_hold;
    vmax    = (hmax > lb[lb_idx]) ? hmax : lb[lb_idx];
    relu    = vmax[I_BW-1] ? '0 : vmax;
    shifted = relu >>> Q_SHIFT;
    sat     = (shifted > O_MAX) ? O_MAX[O_BW-1:0] : shifted[O_BW-1:0];
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col            <= '0;
      row            <= '0;
      ch             <= '0;
      h_hold         <= '0;
      o_pool_result  <= '0;
      o_pool_valid   <= 1'b0;
      o_pool_end     <= 1'b0;
      o_pool_all_end <= 1'b0;
    end else if (rst) begin
      col            <= '0;
      row            <= '0;
      ch             <= '0;
      h_hold         <= '0;
      o_pool_result  <= '0;
      o_pool_valid   <= 1'b0;
      o_pool_end     <= 1'b0;
      o_pool_all_end <= 1'b0;
    end else begin
      o_pool_valid   <= 1'b0;
      o_pool_end     <= 1'b0;
      // Registered off the channel count, so it lags the final o_pool_end by one cycle.
      o_pool_all_end <= (ch == CH_DONE);
      if (accept) begin
        if (!col[0]) begin
          h_hold <= i_conv_result;
        end else if (row[0]) begin
          o_pool_valid  <= 1'b1;
          o_pool_result <= sat;
          o_pool_end    <= last;
        end
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (last) ch <= ch + 1'b1;
      end
    end
  end

  // Line buffer needs no reset: each entry is rewritten on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) lb[lb_idx] <= hmax;
  end

endmodule

// File: tb/tb_relu_maxpool_22_layer2.sv
// tb/tb_relu_maxpool_22_layer2.sv - self-checking bench for relu_maxpool_22_layer2
// Two instances (Q_SHIFT 0 and 2) share stimulus; a frame-level model predicts every output cycle.
module tb_relu_maxpool_22_layer2;
  localparam int I_BW = 20;
  localparam int O_BW = 16;
  localparam int C    = 8;
  localparam int CO   = 4;

  logic                   clk = 1'b0;
  logic                   global_rst_n = 1'b0;
  logic                   rst = 1'b0;
  logic signed [I_BW-1:0] i_conv_result = '0;
  logic                   i_conv_valid = 1'b0;
  logic [O_BW-1:0]        res0, res2;
  logic                   val0, val2, end0, end2, all0, all2;

  relu_maxpool_22_layer2 #(.I_BW(I_BW), .O_BW(O_BW), .C_SIZE(C), .CO(CO), .Q_SHIFT(0)) dut0 (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst),
    .i_conv_result(i_conv_result), .i_conv_valid(i_conv_valid),
    .o_pool_result(res0), .o_pool_valid(val0), .o_pool_end(end0), .o_pool_all_end(all0));

  relu_maxpool_22_layer2 #(.I_BW(I_BW), .O_BW(O_BW), .C_SIZE(C), .CO(CO), .Q_SHIFT(2)) dut2 (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst),
    .i_conv_result(i_conv_result), .i_conv_valid(i_conv_valid),
    .o_pool_result(res2), .o_pool_valid(val2), .o_pool_end(end2), .o_pool_all_end(all2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int q);
    int s;
    s = (v < 0) ? 0 : v;
    s = s >>> q;
    return (s > 32767) ? 32767 : s;
  endfunction

  // Model: store accepted samples by raster position, pool each completed 2x2 window.
  int fr [C][C];
  int k = 0, chn = 0;
  bit m_valid = 0, m_end = 0, m_all = 0;
  int m_r0 = 0, m_r2 = 0;

  always @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n || rst) begin
      k = 0; chn = 0; m_valid = 0; m_end = 0; m_all = 0; m_r0 = 0; m_r2 = 0;
    end else begin
      m_all   = (chn == CO);
      m_valid = 0;
      m_end   = 0;
      if (i_conv_valid && chn < CO) begin
        int r, c, v;
        r = k / C;
        c = k % C;
        fr[r][c] = int'(i_conv_result);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          v = fr[r-1][c-1];
          if (fr[r-1][c] > v) v = fr[r-1][c];
          if (fr[r][c-1] > v) v = fr[r][c-1];
          if (fr[r][c] > v)   v = fr[r][c];
          m_valid = 1;
          m_r0    = sat(v, 0);
          m_r2    = sat(v, 2);
          m_end   = (k == C*C - 1);
        end
        k++;
        if (k == C*C) begin
          k = 0;
          chn++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("q0_valid", int'(val0), int'(m_valid));
    check("q0_result", int'(res0), m_r0);
    check("q0_end", int'(end0), int'(m_end));
    check("q0_all_end", int'(all0), int'(m_all));
    check("q2_valid", int'(val2), int'(m_valid));
    check("q2_result", int'(res2), m_r2);
    check("q2_end", int'(end2), int'(m_end));
    check("q2_all_end", int'(all2), int'(m_all));
  end

  int obs0[$];
  int obs2[$];
  int n_end = 0;
  always @(negedge clk) begin
    if (val0) obs0.push_back(int'(res0));
    if (val2) obs2.push_back(int'(res2));
    if (end0) n_end++;
  end

  int img [C*C];
  int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

  task automatic drive(input int v, input bit vld);
    @(negedge clk);
    i_conv_result = I_BW'(v);
    i_conv_valid  = vld;
  endtask

  task automatic send_img(input int gmax, input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      repeat (g) drive(0, 1'b0);
      drive(img[i], 1'b1);
    end
  endtask

  task automatic finish_img();
    repeat (3) drive(0, 1'b0);
  endtask

  task automatic ramp_img(input int off);
    for (int i = 0; i < C*C; i++) img[i] = i + off;
  endtask

  task automatic check_ramp(input string nm);
    check({nm, "_count"}, obs0.size(), 16);
    for (int i = 0; i < 16 && i < obs0.size(); i++) check({nm, "_val"}, obs0[i], ramp_exp[i]);
  endtask

  task automatic pulse_rst(input bit with_valid);
    @(negedge clk);
    rst = 1'b1;
    i_conv_valid  = with_valid;
    i_conv_result = I_BW'(77);
    @(negedge clk);
    rst = 1'b0;
    i_conv_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("reset_result", int'(res0), 0);
    check("reset_valid", int'(val0), 0);
    check("reset_end", int'(end0), 0);
    check("reset_all_end", int'(all0), 0);
    #20 global_rst_n = 1'b1;

    // Ramp
    obs0.delete(); obs2.delete(); n_end = 0;
    ramp_img(0);
    send_img(0, C*C);
    finish_img();
    check_ramp("ramp");
    check("ramp_end_pulses", n_end, 1);

    // ReLU: all negative, then one negative window among zeros
    obs0.delete(); obs2.delete();
    for (int i = 0; i < C*C; i++) img[i] = -5;
    send_img(0, C*C);
    finish_img();
    check("relu_count", obs0.size(), 16);
    check("relu_first", (obs0.size() > 0) ? obs0[0] : -1, 0);
    obs0.delete();
    for (int i = 0; i < C*C; i++) img[i] = 0;
    img[0] = -3; img[1] = -1; img[C] = -7; img[C+1] = -2;
    send_img(0, C*C);
    finish_img();
    check("relu_window", (obs0.size() > 0) ? obs0[0] : -1, 0);

    // Saturation, with rst colliding with a valid sample
    pulse_rst(1'b1);
    obs0.delete(); obs2.delete();
    for (int i = 0; i < C*C; i++) img[i] = 0;
    img[C+1] = 200000;
    img[2]   = 400;
    send_img(0, C*C);
    finish_img();
    check("sat_q2_big", (obs2.size() > 1) ? obs2[0] : -1, 32767);
    check("sat_q2_400", (obs2.size() > 1) ? obs2[1] : -1, 100);
    check("sat_q0_big", (obs0.size() > 1) ? obs0[0] : -1, 32767);
    check("sat_q0_400", (obs0.size() > 1) ? obs0[1] : -1, 400);

    // Gapped valid
    pulse_rst(1'b0);
    obs0.delete(); obs2.delete();
    ramp_img(0);
    send_img(2, C*C);
    finish_img();
    check_ramp("gapped");

    // Four channels back to back
    pulse_rst(1'b0);
    n_end = 0;
    for (int f = 0; f < CO; f++) begin
      ramp_img(100 * f);
      send_img(0, C*C);
    end
    finish_img();
    check("ch_end_pulses", n_end, 4);
    check("ch_all_end", int'(all0), 1);
    obs0.delete();
    ramp_img(0);
    send_img(0, 20);
    finish_img();
    check("ch_ignored", obs0.size(), 0);
    check("ch_all_end_held", int'(all0), 1);
    pulse_rst(1'b1);
    @(negedge clk);
    check("ch_rst_all_end", int'(all0), 0);
    check("ch_rst_valid", int'(val0), 0);
    check("ch_rst_end", int'(end0), 0);

    // Asynchronous reset at row 3, col 5
    ramp_img(0);
    send_img(0, 3*C + 6);
    @(posedge clk);
    #2;
    global_rst_n = 1'b0;
    i_conv_valid = 1'b0;
    #1;
    check("async_result", int'(res0), 0);
    check("async_valid", int'(val0), 0);
    @(negedge clk);
    #3 global_rst_n = 1'b1;
    obs0.delete(); obs2.delete();
    send_img(0, C*C);
    finish_img();
    check_ramp("after_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_22_layer2.md
# relu_maxpool_22_layer2

Post-processing stage for the second convolution layer. It consumes the raster-order signed stream from the 5x5 convolution engine (one result per valid cycle, one output channel at a time) and applies ReLU and 2x2 stride-2 max pooling. It then rescales and saturates each pooled value to the feature-map width and emits a pooled stream, with per-channel and all-channel end flags, to the flatten / fully-connected stage.

## Interface
Parameters:
- I_BW, 20: input width; equals the convolution O_CONV_BW. Signed.
- O_BW, 16: output width. Signed, always non-negative.
- C_SIZE, 8: side length of the convolution output map. Even, at least 2.
- CO, 4: number of output channels per frame.
- Q_SHIFT, 0: arithmetic right shift applied after pooling.

Ports (the clock and reset are decided: one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all state changes on the rising edge.
- global_rst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous clear of all state, including the channel counter; highest priority after global_rst_n.
- i_conv_result  in  I_BW  signed convolution sample.
- i_conv_valid  in  1  i_conv_result is valid this cycle.
- o_pool_result  out  O_BW  pooled, ReLU'd, saturated value.
- o_pool_valid  out  1  o_pool_result is valid; one-cycle pulse per pooled pixel.
- o_pool_end  out  1  one-cycle pulse coincident with the last pooled pixel of a channel.
- o_pool_all_end  out  1  level; high once CO channels are complete.

## Operation
Counters:
- col and row: clog2(C_SIZE)-bit counters. col advances on each accepted sample and wraps at C_SIZE-1; row advances on col wrap.
- ch: a clog2(CO)+1-bit counter.
- Cycles without i_conv_valid hold all state. Gaps are allowed anywhere.

Horizontal stage:
- Even col: register the sample in h_hold.
- Odd col: hmax = signed max(h_hold, sample).

Line buffer:
- C_SIZE/2 entries of I_BW bits, indexed by col>>1.
- Even row, odd col: write hmax into lb[col>>1]. No output.
- Odd row, odd col: vmax = signed max(hmax, lb[col>>1]); this generates an output.

Output arithmetic:
- r = (vmax < 0) ? 0 : vmax (ReLU).
- s = r >>> Q_SHIFT.
- If s > 2^(O_BW-1)-1, output 2^(O_BW-1)-1; otherwise output s[O_BW-1:0].

Frame end:
- When the sample at row = C_SIZE-1, col = C_SIZE-1 is accepted, row and col return to 0, o_pool_end fires with that pixel, and ch increments.
- o_pool_all_end = (ch == CO). Once set, it stays set until rst or global_rst_n.
- Samples arriving while o_pool_all_end is high are ignored: no counter movement and no output.

Line buffer contents are not cleared between channels. Every entry is rewritten on the even row before it is read.

## Timing
- Reset (global_rst_n low, or rst high at a clock edge): o_pool_result=0, o_pool_valid=0, o_pool_end=0, o_pool_all_end=0. col, row, ch and h_hold are cleared to 0.
- Latency: o_pool_valid rises exactly 1 cycle after the accepting edge of the odd-row, odd-col sample. The output is registered; there is no combinational input-to-output path.
- Output rate: one output per two accepted samples on odd rows, none on even rows. (C_SIZE/2)^2 outputs per channel.
- o_pool_result holds its last value while o_pool_valid is low.
- rst together with i_conv_valid in the same cycle: rst wins and the sample is dropped.
- A rst or reset mid-channel discards the partial window. The next sample is treated as row 0, col 0.
- o_pool_all_end rises 1 cycle after the final o_pool_end edge, i.e. in the cycle following the last output.
- Throughput: a new sample can be accepted every cycle with no backpressure. The upstream convolution stream is never stalled.

## Test plan
- Ramp: C_SIZE=8, input value = row*8+col with i_conv_valid held high. Expect 16 outputs of value 9, 11, 13, 15, 25, ..., 63, each 1 cycle after its odd/odd sample. o_pool_end accompanies the value 63.
- ReLU: all samples = -5. Expect 16 outputs of 0. Then one window with {-3, -1, -7, -2} and the rest 0: that window outputs 0.
- Saturation: Q_SHIFT=2, window max = 200000. Expect 32767. A window max of 400 gives 100.
- Gapped valid: the ramp stimulus with i_conv_valid toggled 1-0-0-1 pseudo-randomly. The output values and their order are identical to the ramp scenario. o_pool_valid occurs only after accepted samples.
- Channels: 4 back-to-back ramp frames, each offset by +100. Expect 4 o_pool_end pulses and o_pool_all_end high after the 4th. Further valid samples produce no output until rst, after which all flags are 0.
- Reset mid-operation: assert global_rst_n low at row 3, col 5 (asynchronously, off the clock edge). Outputs go to 0 immediately. After release, a full ramp frame yields the exact ramp-scenario outputs.
